// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV control unit with memory handshakes, branches and traps
// Sequences FETCH..WB, drives datapath flags (Mealy on ready/alu_zero/decode), sticky trap and retire count.
module multicycle_control_fsm #(
  parameter int INSTR_W     = 32,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               alu_zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCSource,
  output logic               ALUSrcA,
  output logic               LoadAOut,
  output logic               RegWrite,
  output logic               LoadRegA,
  output logic               LoadRegB,
  output logic               MemToReg,
  output logic               DMemOp,
  output logic               LoadMDR,
  output logic               IMemRead,
  output logic               IRWrite,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state_dbg
);

  localparam logic [ALUOP_W-1:0] OP_SUM    = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_SUB    = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_SHL    = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_LESS   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_SRL    = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_SRA    = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] OP_AND    = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] OP_LOAD   = ALUOP_W'(7);

  localparam logic       PCS_ALU_OUT = 1'b0;
  localparam logic       PCS_ALU_REG = 1'b1;
  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_REG_A  = 1'b1;
  localparam logic [1:0] SRCB_REG_B  = 2'd0;
  localparam logic [1:0] SRCB_CONST4 = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM2   = 2'd3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [7:0] WAIT_LAST     = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_START = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
    S_EXEC_R = 4'd4, S_EXEC_I = 4'd5, S_EXEC_U = 4'd6, S_BRANCH = 4'd7,
    S_MEM_LD = 4'd8, S_MEM_SD = 4'd9, S_LD_WB = 4'd10, S_ALU_WB = 4'd11,
    S_TRAP = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_wait;
  logic             r_trap;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_retired;
  logic [1:0]       w_cause;
  logic             w_retire;
  logic             w_wait_last;
  logic [6:0]       w_opcode;
  logic [2:0]       w_funct3;
  logic [6:0]       w_funct7;
  logic             w_unused;

  assign w_opcode    = instruction[6:0];
  assign w_funct3    = instruction[14:12];
  assign w_funct7    = instruction[31:25];
  assign w_unused    = ^{instruction[24:15], instruction[11:7]};
  assign w_wait_last = (r_wait == WAIT_LAST);

  assign trap       = r_trap;
  assign trap_cause = r_cause;
  assign retired    = r_retired;
  assign state_dbg  = r_state;

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; PCSource = PCS_ALU_OUT; ALUSrcA = SRCA_PC;
    LoadAOut = 1'b0; RegWrite = 1'b0; LoadRegA = 1'b0; LoadRegB = 1'b0;
    MemToReg = 1'b0; DMemOp = 1'b0; LoadMDR = 1'b0; IMemRead = 1'b0; IRWrite = 1'b0;
    ALUSrcB = SRCB_REG_B; ALUOp = OP_SUM;
    w_next = r_state; w_cause = 2'd0; w_retire = 1'b0;
    case (r_state)
      S_START: w_next = S_FETCH;
      S_FETCH: begin
        IMemRead = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1; PCWrite = 1'b1; PCSource = PCS_ALU_OUT;
          ALUSrcA = SRCA_PC; ALUSrcB = SRCB_CONST4; w_next = S_DECODE;
        end else if (w_wait_last) begin
          w_next = S_TRAP; w_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        LoadRegA = 1'b1; LoadRegB = 1'b1; LoadAOut = 1'b1;
        ALUSrcA = SRCA_PC; ALUSrcB = SRCB_IMM2;
        case (w_opcode)
          OPC_LOAD, OPC_STORE: w_next = S_MEM_ADDR;
          OPC_R:               w_next = S_EXEC_R;
          OPC_I:               w_next = S_EXEC_I;
          OPC_LUI:             w_next = S_EXEC_U;
          OPC_BRANCH:          w_next = S_BRANCH;
          default: begin w_next = S_TRAP; w_cause = CAUSE_ILLEGAL; end
        endcase
      end
      S_MEM_ADDR: begin
        LoadAOut = 1'b1; ALUSrcA = SRCA_REG_A; ALUSrcB = SRCB_IMM;
        w_next = (w_opcode == OPC_STORE) ? S_MEM_SD : S_MEM_LD;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_REG_A; ALUSrcB = SRCB_REG_B; LoadAOut = 1'b1; w_next = S_ALU_WB;
        case (w_funct3)
          3'b000:  ALUOp = w_funct7[5] ? OP_SUB : OP_SUM;
          3'b001:  ALUOp = OP_SHL;
          3'b111:  ALUOp = OP_AND;
          default: begin LoadAOut = 1'b0; w_next = S_TRAP; w_cause = CAUSE_ILLEGAL; end
        endcase
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_REG_A; ALUSrcB = SRCB_IMM; LoadAOut = 1'b1; w_next = S_ALU_WB;
        case (w_funct3)
          3'b000:  ALUOp = OP_SUM;
          3'b001:  ALUOp = OP_SHL;
          3'b010:  ALUOp = OP_LESS;
          3'b101:  ALUOp = (w_funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
          default: begin LoadAOut = 1'b0; w_next = S_TRAP; w_cause = CAUSE_ILLEGAL; end
        endcase
      end
      S_EXEC_U: begin
        ALUOp = OP_LOAD; ALUSrcB = SRCB_IMM; LoadAOut = 1'b1; w_next = S_ALU_WB;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_REG_A; ALUSrcB = SRCB_REG_B; ALUOp = OP_SUB; PCSource = PCS_ALU_REG;
        case (w_funct3)
          3'b000:  begin PCWriteCond = alu_zero;  w_next = S_FETCH; w_retire = 1'b1; end
          3'b001:  begin PCWriteCond = !alu_zero; w_next = S_FETCH; w_retire = 1'b1; end
          default: begin w_next = S_TRAP; w_cause = CAUSE_ILLEGAL; end
        endcase
      end
      S_MEM_LD: begin
        LoadMDR = 1'b1; DMemOp = 1'b0;
        if (dmem_ready) w_next = S_LD_WB;
        else if (w_wait_last) begin w_next = S_TRAP; w_cause = CAUSE_TIMEOUT; end
      end
      S_MEM_SD: begin
        DMemOp = 1'b1;
        if (dmem_ready) begin w_next = S_FETCH; w_retire = 1'b1; end
        else if (w_wait_last) begin w_next = S_TRAP; w_cause = CAUSE_TIMEOUT; end
      end
      S_LD_WB:  begin RegWrite = 1'b1; MemToReg = 1'b1; w_next = S_FETCH; w_retire = 1'b1; end
      S_ALU_WB: begin RegWrite = 1'b1; MemToReg = 1'b0; w_next = S_FETCH; w_retire = 1'b1; end
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_START;
    endcase
    // reset must not let a half-finished instruction commit on its cycle
    if (reset) begin
      PCWrite = 1'b0; PCWriteCond = 1'b0; PCSource = PCS_ALU_OUT; ALUSrcA = SRCA_PC;
      LoadAOut = 1'b0; RegWrite = 1'b0; LoadRegA = 1'b0; LoadRegB = 1'b0;
      MemToReg = 1'b0; DMemOp = 1'b0; LoadMDR = 1'b0; IMemRead = 1'b0; IRWrite = 1'b0;
      ALUSrcB = SRCB_REG_B; ALUOp = OP_SUM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_START;
      r_wait    <= 8'd0;
      r_trap    <= 1'b0;
      r_cause   <= 2'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= 8'd0;
      else if (r_state inside {S_FETCH, S_MEM_LD, S_MEM_SD})
        r_wait <= r_wait + 8'd1;
      if (w_next == S_TRAP && r_state != S_TRAP) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause;
      end
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_BNE  = 32'h00209063;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset, alu_zero, imem_ready, dmem_ready;
  logic [31:0] instruction;
  logic PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, RegWrite, LoadRegA;
  logic LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite, trap;
  logic [1:0]  ALUSrcB, trap_cause;
  logic [3:0]  ALUOp, state_dbg;
  logic [31:0] retired;
  logic [12:0] flags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign flags = {PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, RegWrite, LoadRegA,
                  LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite};

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .LoadAOut(LoadAOut), .RegWrite(RegWrite), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
    .MemToReg(MemToReg), .DMemOp(DMemOp), .LoadMDR(LoadMDR), .IMemRead(IMemRead),
    .IRWrite(IRWrite), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .trap(trap),
    .trap_cause(trap_cause), .retired(retired), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // from a FETCH cycle: load instr, pass DECODE, land in the dispatched state
  task automatic issue(input logic [31:0] instr);
    instruction = instr;
    imem_ready  = 1'b1;
    tick(); tick(); #1;
  endtask

  initial begin
    reset = 1'b1; instruction = I_ADD; alu_zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
    tick(); #1;
    check("rst_state", state_dbg, 0);
    check("rst_flags", flags, 0);
    check("rst_aluop", ALUOp, 0);
    tick(); reset = 1'b0; #1;
    check("start_state", state_dbg, 0);
    check("start_retired", retired, 0);
    check("start_trap", {trap, trap_cause}, 0);

    tick(); #1;
    check("fetch_state", state_dbg, 1);
    check("fetch_pcw_irw", {PCWrite, IRWrite, IMemRead}, 3'b111);
    check("fetch_srcb", ALUSrcB, 1);
    tick(); #1;
    check("decode_state", state_dbg, 2);
    check("decode_loads", {LoadRegA, LoadRegB, LoadAOut}, 3'b111);
    check("decode_srcb", ALUSrcB, 3);
    tick(); #1;
    check("add_state", state_dbg, 4);
    check("add_aluop", ALUOp, 0);
    check("add_srcs", {ALUSrcA, ALUSrcB}, 3'b100);
    tick(); #1;
    check("add_wb_state", state_dbg, 11);
    check("add_wb_flags", {RegWrite, MemToReg}, 2'b10);
    tick(); #1;
    check("add_retired", retired, 1);

    issue(I_SUB);
    check("sub_aluop", ALUOp, 1);
    tick(); tick(); #1;
    check("sub_retired", retired, 2);

    alu_zero = 1'b0;
    issue(I_BNE);
    check("bne_state", state_dbg, 7);
    check("bne_taken", {PCWriteCond, PCSource}, 2'b11);
    check("bne_aluop", ALUOp, 1);
    tick(); #1;
    check("bne_retired", {state_dbg, retired}, {4'd1, 32'd3});
    alu_zero = 1'b1;
    issue(I_BNE);
    check("bne_not_taken", PCWriteCond, 0);
    tick(); #1;
    issue(I_BEQ);
    check("beq_taken", PCWriteCond, 1);
    tick(); #1;
    check("branch_retired", retired, 5);

    dmem_ready = 1'b0;
    issue(I_LW);
    check("lw_addr", {state_dbg, LoadAOut, ALUSrcB}, {4'd3, 1'b1, 2'd2});
    tick(); #1;
    for (int i = 0; i < 5; i++) begin
      check("lw_wait", {state_dbg, LoadMDR, DMemOp}, {4'd8, 2'b10});
      tick(); #1;
    end
    dmem_ready = 1'b1; #1;
    check("lw_ready", {state_dbg, LoadMDR}, {4'd8, 1'b1});
    tick(); dmem_ready = 1'b0; #1;
    check("lw_wb", {state_dbg, RegWrite, MemToReg}, {4'd10, 2'b11});
    check("lw_no_trap", trap, 0);
    tick(); #1;
    check("lw_retired", retired, 6);

    dmem_ready = 1'b1;
    issue(I_SW);
    tick(); #1;
    check("sw_state", {state_dbg, DMemOp}, {4'd9, 1'b1});
    tick(); #1;
    check("sw_retired", {state_dbg, retired}, {4'd1, 32'd7});

    issue(I_SRAI);
    check("srai_aluop", {state_dbg, ALUOp}, {4'd5, 4'd5});
    tick(); tick(); #1;
    check("srai_retired", retired, 8);

    instruction = I_ADD;
    imem_ready  = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1;
      check("iwait", {state_dbg, IRWrite, PCWrite}, {4'd1, 2'b00});
      tick();
    end
    imem_ready = 1'b1; #1;
    check("ready_last_cycle", {state_dbg, IRWrite}, {4'd1, 1'b1});
    tick(); #1;
    check("ready_wins", {state_dbg, trap}, {4'd2, 1'b0});
    tick(); tick(); tick(); #1;
    check("late_retired", retired, 9);

    imem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("to_wait", state_dbg, 1);
      tick();
    end
    #1;
    check("timeout_state", state_dbg, 15);
    check("timeout_trap", {trap, trap_cause}, {1'b1, 2'd2});
    check("timeout_flags", flags, 0);
    tick(); tick(); #1;
    check("trap_sticky", {state_dbg, trap}, {4'd15, 1'b1});

    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    check("rst2_state", {state_dbg, trap, trap_cause}, {4'd0, 3'd0});
    check("rst2_retired", retired, 0);

    tick(); #1;
    issue(I_BAD);
    check("illegal_trap", {state_dbg, trap, trap_cause}, {4'd15, 1'b1, 2'd1});
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    check("rst3", {state_dbg, trap, trap_cause}, {4'd0, 3'd0});
    check("rst3_retired", retired, 0);

    imem_ready = 1'b1;
    tick(); #1;
    reset = 1'b1; #1;
    check("rst_gate_fetch", flags, 0);
    tick(); reset = 1'b0; #1;
    check("rst_abort", {state_dbg, retired}, {4'd0, 32'd0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
